mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/mc_controller_if.sv | 29 ++
 rtl/mc_controller_alu_decoder.sv | 31 +++
 rtl/mc_controller.sv | 134 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the multicycle controller and ALU
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - instruction fields in, datapath control signals out
interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;

  modport master (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, imm_src, alu_control
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
    output result_src, alu_src_a, alu_src_b, imm_src, alu_control
  );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// rtl/mc_controller_alu_decoder.sv - maps aluop and instruction fields to an ALU operation
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type with funct7b5 set is sub; addi never subtracts
          3'b000:  alu_control = ({op5, funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RISC-V control FSM with Moore control outputs
module mc_controller
  import riscv_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mc_controller_if.slave bus
);

  state_t     state;
  state_t     cur;
  logic [1:0] aluop;
  logic [2:0] alu_control;
  logic       pc_update;
  logic       branch;
  logic       ir_w;
  logic       mem_w;
  logic       reg_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTER;
            OP_ITYPE:     state <= S_EXECUTEI;
            OP_JAL:       state <= S_JAL;
            OP_BEQ:       state <= S_BEQ;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  state <= S_MEMWB;
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // While reset is held the outputs show FETCH regardless of the stored state
  always_comb begin
    cur            = rst_n ? state : S_FETCH;
    bus.adr_src    = 1'b0;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RS2;
    aluop          = ALUOP_ADD;
    pc_update      = 1'b0;
    branch         = 1'b0;
    ir_w           = 1'b0;
    mem_w          = 1'b0;
    reg_w          = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_w           = 1'b1;
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALURESULT;
        pc_update      = 1'b1;
      end
      S_DECODE: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: bus.adr_src = 1'b1;
      S_MEMWB: begin
        bus.result_src = RES_DATA;
        reg_w          = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adr_src = 1'b1;
        mem_w       = 1'b1;
      end
      S_EXECUTER: begin
        bus.alu_src_a = SRCA_RS1;
        aluop         = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        aluop         = ALUOP_FUNCT;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BEQ: begin
        bus.alu_src_a = SRCA_RS1;
        aluop         = ALUOP_SUB;
        branch        = 1'b1;
      end
      S_JAL: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_FOUR;
        pc_update     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.pc_write  = rst_n & (pc_update | (branch & bus.zero));
    bus.ir_write  = rst_n & ir_w;
    bus.mem_write = rst_n & mem_w;
    bus.reg_write = rst_n & reg_w;
  end

  always_comb begin
    case (bus.op)
      OP_LW, OP_ITYPE: bus.imm_src = IMM_I;
      OP_SW:           bus.imm_src = IMM_S;
      OP_BEQ:          bus.imm_src = IMM_B;
      OP_JAL:          bus.imm_src = IMM_J;
      default:         bus.imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (bus.funct3),
    .op5         (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (alu_control)
  );

  always_comb bus.alu_control = alu_control;

endmodule
